mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Two-port arbiter/sequencer sharing the single-port LC-3 main RAM between the
//  CPU memory interface (MAR/MDR side) and a DMA/debug loader port. Grants one
//  access at a time, round-robin; strobes the RAM; inserts wait states; returns
//  read data with a one-cycle ready/ack pulse. Sits between cpu and RAM array.
// PARAMETERS
//  WAIT_CYCLES  1   extra ACCESS cycles after the RAM strobe (legal range >= 1)
//  ADDR_W       16  address width
//  DATA_W       16  data width
// PORTS
//  clk        in   1       system clock, all state on rising edge
//  arst       in   1       asynchronous reset, active-high
//  cpu_req    in   1       CPU access request; held until cpu_rdy
//  cpu_we     in   1       1 = write, 0 = read
//  cpu_addr   in   ADDR_W  CPU address (MAR)
//  cpu_wdata  in   DATA_W  CPU write data (MDR)
//  cpu_rdata  out  DATA_W  CPU read data, registered
//  cpu_rdy    out  1       one-cycle completion pulse to CPU
//  dma_req    in   1       DMA access request; held until dma_ack
//  dma_we     in   1       1 = write, 0 = read
//  dma_addr   in   ADDR_W  DMA address
//  dma_wdata  in   DATA_W  DMA write data
//  dma_rdata  out  DATA_W  DMA read data, registered
//  dma_ack    out  1       one-cycle completion pulse to DMA
//  ram_en     out  1       RAM strobe, exactly one cycle per access
//  ram_we     out  1       RAM write enable, only with ram_en
//  ram_addr   out  ADDR_W  latched address of granted access
//  ram_wdata  out  DATA_W  latched write data of granted access
//  ram_rdata  in   DATA_W  RAM sync read data, valid from cycle after ram_en strobe
//  grant      out  2       {dma,cpu} owner of current access, 0 in IDLE
// BEHAVIOUR
//  Reset (async, immediate): state IDLE; all outputs 0; last_grant = DMA.
//  FSM: IDLE -> ACCESS -> RESP -> IDLE. RESP always returns to IDLE.
//  IDLE: on edge with any req: pick winner, latch addr/wdata/we/owner,
//    cnt <= WAIT_CYCLES, go ACCESS. No req: stay.
//  Arbitration: one req -> that port; both -> port != last_grant;
//    last_grant updated on grant. From reset, CPU wins first tie.
//  ACCESS: ram_en=1 (ram_we=latched we) in first ACCESS cycle only.
//    cnt != 0: decrement; cnt == 0: load owner rdata from ram_rdata (reads
//    only; writes leave rdata unchanged), go RESP. ACCESS lasts WAIT_CYCLES+1.
//  RESP: owner rdy/ack high exactly one cycle; other port's pulse stays 0.
//  Latency: req sampled at edge E -> pulse during cycle after edge
//    E+WAIT_CYCLES+1; rdata valid then, held until next read completion.
//  Requester must drop or re-present req at edge ending RESP; req still high
//    in IDLE is a new request. Dropping req mid-access is a protocol
//    violation: access still completes and pulse still issues.
//  Losing port keeps req high; served on next IDLE pass (starvation-free).
//  Inputs are not re-sampled after grant; addr/data changes mid-access ignored.
//  arst during ACCESS/RESP: aborted, no pulse; write either already strobed or
//    not issued (single strobe cycle), never partial.
//  grant: one-hot owner during ACCESS/RESP, 0 in IDLE.
// STRUCTURE
//  mem_arb_defs.vh: `define state encodings (IDLE/ACCESS/RESP), port ids.
//  Sub-module rr_arb2: 2-way round-robin picker (req[1:0], last -> gnt[1:0]),
//    combinational with last_grant register in parent.
//  Parent: FSM, wait counter ($clog2(WAIT_CYCLES+1) bits), latch regs, rdata regs.
// TESTING
//  1 arst pulse mid-idle -> all outputs 0, grant 0, next CPU req wins tie.
//  2 W=1, ram[x3000]=x1234, CPU read x3000 -> one ram_en cycle addr x3000,
//    cpu_rdy one cycle 2 edges after sampling, cpu_rdata=x1234, dma_ack 0.
//  3 DMA write x4000=xBEEF -> ram_en&ram_we one cycle, dma_ack one pulse;
//    then CPU read x4000 -> cpu_rdata=xBEEF.
//  4 Both req held from reset, 6 accesses -> grant order C,D,C,D,C,D.
//  5 W=3 read -> ram_en once, pulse 4 edges after sampling, cnt wraps no further.
//  6 arst in 2nd ACCESS cycle -> ram_en/rdy/ack 0 at once, no pulse;
//    re-issued request completes normally with correct data.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the LC-3 main-RAM arbiter: FSM states and port identifiers.
package mem_arbiter_pkg;

  localparam int unsigned N_PORTS  = 2;
  localparam int unsigned PORT_CPU = 0;
  localparam int unsigned PORT_DMA = 1;

  // One bit per requester, bit PORT_CPU = CPU, bit PORT_DMA = DMA/loader.
  typedef logic [N_PORTS-1:0] port_vec_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Arbiter bus: CPU request port, DMA/loader request port and the RAM-side strobe.
interface mem_arbiter_if
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16
);

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_rdy;

  logic              dma_req;
  logic              dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic [DATA_W-1:0] dma_rdata;
  logic              dma_ack;

  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  port_vec_t         grant;

  // Arbiter view.
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    input  ram_rdata,
    output cpu_rdata, cpu_rdy, dma_rdata, dma_ack,
    output ram_en, ram_we, ram_addr, ram_wdata, grant
  );

  // Requester / RAM environment view.
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output dma_req, dma_we, dma_addr, dma_wdata,
    output ram_rdata,
    input  cpu_rdata, cpu_rdy, dma_rdata, dma_ack,
    input  ram_en, ram_we, ram_addr, ram_wdata, grant
  );

endinterface

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin picker; the last-grant register lives in the parent.
module rr_arb2
  import mem_arbiter_pkg::*;
(
  input  port_vec_t i_req,
  input  logic      i_last,   // 1: DMA won the previous grant
  output port_vec_t o_gnt_c
);

  // Single requester wins outright; a tie goes to the port that did not win last.
  always_comb begin
    o_gnt_c = '0;
    if (i_req == 2'b11) begin
      o_gnt_c[PORT_CPU] = i_last;
      o_gnt_c[PORT_DMA] = ~i_last;
    end else begin
      o_gnt_c = i_req;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter/sequencer sharing the single-port main RAM between CPU and DMA ports.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 1,
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned DATA_W      = 16
) (
  input  logic          clk,
  input  logic          arst,
  mem_arbiter_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(WAIT_CYCLES + 1);

  state_e            r_state;
  state_e            w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;

  logic              r_last;     // 1: DMA owned the previous access
  logic              r_owner;    // 1: DMA owns the current access
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_cpu_rdata;
  logic [DATA_W-1:0] r_dma_rdata;
  logic              r_cpu_rdy;
  logic              r_dma_ack;
  logic              r_ram_en;
  logic              r_ram_we;
  port_vec_t         r_grant;

  port_vec_t         w_req;
  port_vec_t         w_gnt;
  logic              w_sel_dma;
  logic              w_we_sel;
  logic [ADDR_W-1:0] w_addr_sel;
  logic [DATA_W-1:0] w_wdata_sel;
  logic              w_take;
  logic              w_done;
  logic              w_ram_en_nxt;
  logic              w_cpu_rdy_nxt;
  logic              w_dma_ack_nxt;
  port_vec_t         w_grant_nxt;

  assign w_req = {bus.dma_req, bus.cpu_req};

  rr_arb2 u_rr (
    .i_req   (w_req),
    .i_last  (r_last),
    .o_gnt_c (w_gnt)
  );

  // Steer the winning port's request fields toward the latch registers.
  always_comb begin
    w_sel_dma   = w_gnt[PORT_DMA];
    w_we_sel    = w_sel_dma ? bus.dma_we    : bus.cpu_we;
    w_addr_sel  = w_sel_dma ? bus.dma_addr  : bus.cpu_addr;
    w_wdata_sel = w_sel_dma ? bus.dma_wdata : bus.cpu_wdata;
  end

  // FSM state and wait counter.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next state plus the next values of the registered strobes and pulses.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_take        = 1'b0;
    w_done        = 1'b0;
    w_ram_en_nxt  = 1'b0;
    w_cpu_rdy_nxt = 1'b0;
    w_dma_ack_nxt = 1'b0;
    w_grant_nxt   = r_grant;
    unique case (r_state)
      ST_IDLE: begin
        if (|w_req) begin
          w_take       = 1'b1;
          w_state_nxt  = ST_ACCESS;
          w_cnt_nxt    = CNT_W'(WAIT_CYCLES);
          w_ram_en_nxt = 1'b1;
          w_grant_nxt  = w_gnt;
        end
      end
      ST_ACCESS: begin
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end else begin
          w_done        = 1'b1;
          w_state_nxt   = ST_RESP;
          w_cpu_rdy_nxt = ~r_owner;
          w_dma_ack_nxt = r_owner;
        end
      end
      ST_RESP: begin
        w_state_nxt = ST_IDLE;
        w_grant_nxt = '0;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_grant_nxt = '0;
      end
    endcase
  end

  // Request latches, RAM strobe, completion pulses and per-port read data.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_last      <= 1'b1;
      r_owner     <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_cpu_rdata <= '0;
      r_dma_rdata <= '0;
      r_cpu_rdy   <= 1'b0;
      r_dma_ack   <= 1'b0;
      r_ram_en    <= 1'b0;
      r_ram_we    <= 1'b0;
      r_grant     <= '0;
    end else begin
      r_ram_en  <= w_ram_en_nxt;
      r_ram_we  <= w_ram_en_nxt & w_we_sel;
      r_cpu_rdy <= w_cpu_rdy_nxt;
      r_dma_ack <= w_dma_ack_nxt;
      r_grant   <= w_grant_nxt;
      if (w_take) begin
        r_owner <= w_sel_dma;
        r_last  <= w_sel_dma;
        r_we    <= w_we_sel;
        r_addr  <= w_addr_sel;
        r_wdata <= w_wdata_sel;
      end
      if (w_done && !r_we) begin
        if (r_owner) r_dma_rdata <= bus.ram_rdata;
        else         r_cpu_rdata <= bus.ram_rdata;
      end
    end
  end

  assign bus.cpu_rdata = r_cpu_rdata;
  assign bus.cpu_rdy   = r_cpu_rdy;
  assign bus.dma_rdata = r_dma_rdata;
  assign bus.dma_ack   = r_dma_ack;
  assign bus.ram_en    = r_ram_en;
  assign bus.ram_we    = r_ram_we;
  assign bus.ram_addr  = r_addr;
  assign bus.ram_wdata = r_wdata;
  assign bus.grant     = r_grant;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: one instance with one wait state, one with three.
module tb_mem_arbiter;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;

  logic clk = 1'b0;
  logic arst;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) if0 ();
  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) if3 ();

  mem_arbiter #(.WAIT_CYCLES(1), .ADDR_W(AW), .DATA_W(DW)) u_dut0 (
    .clk (clk), .arst (arst), .bus (if0.slave));
  mem_arbiter #(.WAIT_CYCLES(3), .ADDR_W(AW), .DATA_W(DW)) u_dut3 (
    .clk (clk), .arst (arst), .bus (if3.slave));

  // RAM arrays with synchronous read, one per instance.
  logic [DW-1:0] ram0 [0:65535];
  logic [DW-1:0] ram3 [0:65535];
  always @(posedge clk) begin
    if (if0.ram_en) begin
      if (if0.ram_we) ram0[if0.ram_addr] <= if0.ram_wdata;
      else            if0.ram_rdata      <= ram0[if0.ram_addr];
    end
    if (if3.ram_en) begin
      if (if3.ram_we) ram3[if3.ram_addr] <= if3.ram_wdata;
      else            if3.ram_rdata      <= ram3[if3.ram_addr];
    end
  end

  // Reference model: sparse memory image per instance over a known fill pattern.
  logic [15:0] mdl [int];
  function automatic logic [15:0] fill(input logic [15:0] a);
    return a ^ 16'hA5A5;
  endfunction
  function automatic logic [15:0] mdl_rd(input int d, input logic [15:0] a);
    int k;
    k = d * 65536 + int'(a);
    return mdl.exists(k) ? mdl[k] : fill(a);
  endfunction

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    int          due;
  } exp_t;

  exp_t        q [4][$];      // index = instance*2 + port (0 CPU, 1 DMA)
  int          served [$];    // owner order of completions on the one-wait instance
  int          en_cnt [2];
  int          we_cnt [2];
  logic [15:0] en_addr [2];
  logic [15:0] en_wdata [2];
  logic [15:0] last_rd [4];
  int          total = 0;
  int          bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic clear_sb();
    for (int k = 0; k < 4; k++) begin
      q[k].delete();
      last_rd[k] = 16'h0;
    end
    for (int d = 0; d < 2; d++) begin
      en_cnt[d] = 0;
      we_cnt[d] = 0;
    end
  endtask

  // Score one completion pulse against the oldest expectation for that port.
  task automatic mon_port(input int d, input int p, input logic pulse, input logic other,
                          input logic [1:0] gnt, input logic [15:0] rd);
    exp_t e;
    int   k;
    k = d * 2 + p;
    if (!pulse) return;
    if (q[k].size() == 0) begin
      total++;
      bad++;
      $display("FAIL spurious_pulse inst%0d port%0d: got pulse expected none", d, p);
      return;
    end
    e = q[k].pop_front();
    chk("pulse_exclusive", 64'(other), 64'd0);
    chk("grant_owner", 64'(gnt), (p == 0) ? 64'd1 : 64'd2);
    chk("strobe_count", 64'(en_cnt[d]), 64'd1);
    chk("write_strobe", 64'(we_cnt[d]), 64'(e.we));
    chk("ram_addr", 64'(en_addr[d]), 64'(e.addr));
    if (e.we) begin
      chk("ram_wdata", 64'(en_wdata[d]), 64'(e.wdata));
      chk("rdata_hold", 64'(rd), 64'(last_rd[k]));
    end else begin
      chk("rdata", 64'(rd), 64'(e.rdata));
      last_rd[k] = e.rdata;
    end
    if (e.due >= 0) chk("latency", 64'(cyc), 64'(e.due));
    en_cnt[d] = 0;
    we_cnt[d] = 0;
    if (d == 0) served.push_back(p);
  endtask

  // Monitor: samples on the falling edge, decoupled from the stimulus.
  always @(negedge clk) begin
    if (if0.ram_en) begin
      chk("strobe_expected0", 64'((q[0].size() + q[1].size()) != 0), 64'd1);
      en_cnt[0]++;
      if (if0.ram_we) we_cnt[0]++;
      en_addr[0]  = if0.ram_addr;
      en_wdata[0] = if0.ram_wdata;
    end
    if (if3.ram_en) begin
      chk("strobe_expected3", 64'((q[2].size() + q[3].size()) != 0), 64'd1);
      en_cnt[1]++;
      if (if3.ram_we) we_cnt[1]++;
      en_addr[1]  = if3.ram_addr;
      en_wdata[1] = if3.ram_wdata;
    end
    mon_port(0, 0, if0.cpu_rdy, if0.dma_ack, if0.grant, if0.cpu_rdata);
    mon_port(0, 1, if0.dma_ack, if0.cpu_rdy, if0.grant, if0.dma_rdata);
    mon_port(1, 0, if3.cpu_rdy, if3.dma_ack, if3.grant, if3.cpu_rdata);
    mon_port(1, 1, if3.dma_ack, if3.cpu_rdy, if3.grant, if3.dma_rdata);
  end

  task automatic drive(input int d, input int p, input logic req, input logic we,
                       input logic [15:0] a, input logic [15:0] wd);
    if (d == 0 && p == 0) begin
      if0.cpu_req = req; if0.cpu_we = we; if0.cpu_addr = a; if0.cpu_wdata = wd;
    end else if (d == 0) begin
      if0.dma_req = req; if0.dma_we = we; if0.dma_addr = a; if0.dma_wdata = wd;
    end else if (p == 0) begin
      if3.cpu_req = req; if3.cpu_we = we; if3.cpu_addr = a; if3.cpu_wdata = wd;
    end else begin
      if3.dma_req = req; if3.dma_we = we; if3.dma_addr = a; if3.dma_wdata = wd;
    end
  endtask

  function automatic logic pulse_of(input int d, input int p);
    if (d == 0) return (p == 0) ? if0.cpu_rdy : if0.dma_ack;
    return (p == 0) ? if3.cpu_rdy : if3.dma_ack;
  endfunction

  // Present a request (called just after a rising edge) and record what it must return.
  task automatic issue(input int d, input int p, input logic we, input logic [15:0] a,
                       input logic [15:0] wd, input bit lat);
    exp_t e;
    e.we    = we;
    e.addr  = a;
    e.wdata = wd;
    e.rdata = mdl_rd(d, a);
    e.due   = lat ? (cyc + ((d == 0) ? 1 : 3) + 2) : -1;
    if (we) mdl[d * 65536 + int'(a)] = wd;
    q[d * 2 + p].push_back(e);
    drive(d, p, 1'b1, we, a, wd);
  endtask

  task automatic access(input int d, input int p, input logic we, input logic [15:0] a,
                        input logic [15:0] wd, input bit lat);
    bit seen;
    seen = 1'b0;
    issue(d, p, we, a, wd, lat);
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      seen = pulse_of(d, p);
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL timeout inst%0d port%0d: got no pulse expected one within 60 cycles", d, p);
    end
    @(posedge clk);
    #1;
    drive(d, p, 1'b0, 1'b0, 16'h0, 16'h0);
  endtask

  task automatic chk_outs_zero(input string nm);
    chk({nm, "_data0"}, {if0.cpu_rdata, if0.dma_rdata, if0.ram_addr, if0.ram_wdata}, 64'd0);
    chk({nm, "_ctl0"}, 64'({if0.cpu_rdy, if0.dma_ack, if0.ram_en, if0.ram_we, if0.grant}), 64'd0);
    chk({nm, "_data3"}, {if3.cpu_rdata, if3.dma_rdata, if3.ram_addr, if3.ram_wdata}, 64'd0);
    chk({nm, "_ctl3"}, 64'({if3.cpu_rdy, if3.dma_ack, if3.ram_en, if3.ram_we, if3.grant}), 64'd0);
  endtask

  task automatic rand_port(input int p, input int n);
    logic [15:0] a;
    logic [15:0] wd;
    logic        we;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
      end
      a  = {(p == 0) ? 4'h5 : 4'h6, 8'h00, 4'($urandom_range(0, 15))};
      we = 1'($urandom_range(0, 1));
      wd = 16'($urandom);
      access(0, p, we, a, wd, 1'b0);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no end of test expected end before 400000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    arst = 1'b1;
    for (int d = 0; d < 2; d++)
      for (int p = 0; p < 2; p++) drive(d, p, 1'b0, 1'b0, 16'h0, 16'h0);
    for (int i = 0; i < 65536; i++) begin
      ram0[i] = fill(16'(i));
      ram3[i] = fill(16'(i));
    end
    ram0[16'h3000] = 16'h1234;
    ram3[16'h3000] = 16'h1234;
    mdl[16'h3000]          = 16'h1234;
    mdl[65536 + 16'h3000]  = 16'h1234;
    clear_sb();

    repeat (3) @(posedge clk);
    #2;
    chk_outs_zero("reset");
    arst = 1'b0;
    @(posedge clk);
    #1;

    // Single-wait read, then DMA write followed by CPU read-back of it.
    access(0, 0, 1'b0, 16'h3000, 16'h0, 1'b1);
    access(0, 1, 1'b1, 16'h4000, 16'hBEEF, 1'b1);
    access(0, 0, 1'b0, 16'h4000, 16'h0, 1'b1);
    access(0, 1, 1'b0, 16'h3000, 16'h0, 1'b1);

    // Three-wait instance: reads and a write, then idle with no stray strobes.
    access(1, 0, 1'b0, 16'h3000, 16'h0, 1'b1);
    access(1, 1, 1'b1, 16'h0042, 16'h5A5A, 1'b1);
    access(1, 1, 1'b0, 16'h0042, 16'h0, 1'b1);
    access(1, 0, 1'b1, 16'h0077, 16'h1111, 1'b1);
    repeat (8) @(posedge clk);
    #1;

    // Reset pulse while idle, then both ports held: CPU takes the first tie.
    #1;
    arst = 1'b1;
    #1;
    chk_outs_zero("idle_reset");
    clear_sb();
    #1;
    arst = 1'b0;
    @(posedge clk);
    #1;
    served.delete();
    for (int i = 0; i < 3; i++) begin
      issue(0, 0, 1'b0, 16'h3000, 16'h0, 1'b0);
      issue(0, 1, 1'b0, 16'h4000, 16'h0, 1'b0);
    end
    n = 0;
    for (int i = 0; i < 100 && n < 6; i++) begin
      @(negedge clk);
      if (if0.cpu_rdy || if0.dma_ack) n++;
    end
    drive(0, 0, 1'b0, 1'b0, 16'h0, 16'h0);
    drive(0, 1, 1'b0, 1'b0, 16'h0, 16'h0);
    chk("held_pulse_count", 64'(n), 64'd6);
    @(posedge clk);
    #1;
    for (int i = 0; i < 6; i++)
      chk("grant_order", (served.size() > i) ? 64'(served[i]) : 64'd9, 64'(i % 2));
    repeat (4) @(posedge clk);
    #1;

    // Reset in the second access cycle aborts the read; re-issue completes.
    issue(0, 0, 1'b0, 16'h3000, 16'h0, 1'b1);
    @(posedge clk);
    @(posedge clk);
    #2;
    arst = 1'b1;
    #1;
    chk("abort_ctl", 64'({if0.cpu_rdy, if0.dma_ack, if0.ram_en, if0.grant}), 64'd0);
    clear_sb();
    drive(0, 0, 1'b0, 1'b0, 16'h0, 16'h0);
    #1;
    arst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    access(0, 0, 1'b0, 16'h3000, 16'h0, 1'b1);

    // Random traffic from both ports on disjoint address windows.
    fork
      rand_port(0, 30);
      rand_port(1, 30);
    join
    repeat (6) @(posedge clk);
    chk("queues_drained", 64'(q[0].size() + q[1].size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
